// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared command encodings, FSM state type and helpers for
//               the handshaked sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // 4-bit command encodings; 12-15 are reserved and reported as illegal
  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_OR   = 4'd6;
  localparam logic [3:0] CMD_NOR  = 4'd7;
  localparam logic [3:0] CMD_SLTU = 4'd8;
  localparam logic [3:0] CMD_SLL  = 4'd9;
  localparam logic [3:0] CMD_SRL  = 4'd10;
  localparam logic [3:0] CMD_SRA  = 4'd11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // True for the commands that use the iterative shifter
  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CMD_SLL) || (cmd == CMD_SRL) || (cmd == CMD_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_core
// Description : Purely combinational logic/arithmetic core for commands 0-8
//               plus illegal-command detection. Shift commands yield zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cmd_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carryout_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  // Shared adder: subtraction-style commands use a + ~b + 1
  always_comb begin
    sub_sel      = (cmd_i == CMD_SUB) || (cmd_i == CMD_SLT) || (cmd_i == CMD_SLTU);
    b_eff        = sub_sel ? ~b_i : b_i;
    {carry, sum} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    ovf          = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

  // Result and flag selection; flags only meaningful for ADD/SUB
  always_comb begin
    result_o   = '0;
    carryout_o = 1'b0;
    overflow_o = 1'b0;
    illegal_o  = 1'b0;
    case (cmd_i)
      CMD_ADD, CMD_SUB: begin
        result_o   = sum;
        carryout_o = carry;
        overflow_o = ovf;
      end
      CMD_XOR:  result_o = a_i ^ b_i;
      CMD_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      CMD_AND:  result_o = a_i & b_i;
      CMD_NAND: result_o = ~(a_i & b_i);
      CMD_OR:   result_o = a_i | b_i;
      CMD_NOR:  result_o = ~(a_i | b_i);
      CMD_SLTU: result_o = {{(WIDTH-1){1'b0}}, ~carry};
      CMD_SLL, CMD_SRL, CMD_SRA: result_o = '0;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU. Logic/arithmetic ops complete in one cycle;
//               shifts iterate one bit per cycle. Result is held until the
//               consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic               load;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   step;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic               core_ovf;
  logic               core_ill;

  assign shamt = b[SHAMT_W-1:0];

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .cmd_i      (cmd),
    .a_i        (a),
    .b_i        (b),
    .result_o   (core_result),
    .carryout_o (core_carry),
    .overflow_o (core_ovf),
    .illegal_o  (core_ill)
  );

  // One-bit shift of the working register; SRA replicates the MSB, which
  // never changes during an arithmetic shift and so is the original sign
  always_comb begin
    step = work_q;
    case (cmd_q)
      CMD_SLL: step = {work_q[WIDTH-2:0], 1'b0};
      CMD_SRL: step = {1'b0, work_q[WIDTH-1:1]};
      default: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  // Next-state, datapath and output-register update selection
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift(cmd) && (shamt != '0)) begin
            work_d  = a;
            cnt_d   = shamt;
            cmd_d   = cmd;
            state_d = ST_SHIFT;
          end else begin
            // Single-cycle ops, including shift by zero which passes a through
            load     = 1'b1;
            state_d  = ST_HOLD;
            result_d = is_shift(cmd) ? a : core_result;
            carry_d  = core_carry;
            ovf_d    = core_ovf;
            ill_d    = core_ill;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          load     = 1'b1;
          state_d  = ST_HOLD;
          result_d = step;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // zero tracks the result only when a new result is captured
  assign zero_d = load ? (result_d == '0) : zero_q;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      cmd_q    <= CMD_ADD;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq with a 32-bit and an 8-bit
//               instance sharing one stimulus path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel8 = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  cmd_s = 4'd0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;

  logic        iv32, or32, ir32, ov32, c32, o32, z32, il32;
  logic [31:0] r32;
  logic        iv8, or8, ir8, ov8, c8, o8, z8, il8;
  logic [7:0]  r8;

  logic        obs_ir, obs_ov, obs_c, obs_o, obs_z, obs_il;
  logic [31:0] obs_res;

  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign iv32 = in_valid & ~sel8;
  assign or32 = out_ready & ~sel8;
  assign iv8  = in_valid & sel8;
  assign or8  = out_ready & sel8;

  assign obs_ir  = sel8 ? ir8 : ir32;
  assign obs_ov  = sel8 ? ov8 : ov32;
  assign obs_res = sel8 ? {24'd0, r8} : r32;
  assign obs_c   = sel8 ? c8 : c32;
  assign obs_o   = sel8 ? o8 : o32;
  assign obs_z   = sel8 ? z8 : z32;
  assign obs_il  = sel8 ? il8 : il32;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .cmd(cmd_s),
    .a(a_s), .b(b_s), .out_valid(ov32), .out_ready(or32), .result(r32),
    .carryout(c32), .overflow(o32), .zero(z32), .illegal(il32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .cmd(cmd_s),
    .a(a_s[7:0]), .b(b_s[7:0]), .out_valid(ov8), .out_ready(or8), .result(r8),
    .carryout(c8), .overflow(o8), .zero(z8), .illegal(il8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic c, o, z, il, input int lat);
    exp_t e;
    e.res = r; e.c = c; e.o = o; e.z = z; e.ill = il; e.lat = lat;
    return e;
  endfunction

  // Independent 32-bit reference built from native operators
  function automatic exp_t model32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] w;
    longint      s;
    e = mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (c)
      4'd0: begin
        w = {1'b0, x} + {1'b0, y};
        e.res = w[31:0]; e.c = w[32];
        s = longint'($signed(x)) + longint'($signed(y));
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        e.res = x - y; e.c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'd2:  e.res = x ^ y;
      4'd3:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  e.res = x & y;
      4'd5:  e.res = ~(x & y);
      4'd6:  e.res = x | y;
      4'd7:  e.res = ~(x | y);
      4'd8:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd9:  e.res = x << y[4:0];
      4'd10: e.res = x >> y[4:0];
      4'd11: e.res = $signed(x) >>> y[4:0];
      default: e.ill = 1'b1;
    endcase
    if (c >= 4'd9 && c <= 4'd11 && y[4:0] != 5'd0) e.lat = int'(y[4:0]) + 1;
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Issue one op, check latency/busy, compare against scoreboard, then
  // hold with out_ready low for 'hold' cycles while a stray request is offered
  task automatic run_op(input bit w8, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input exp_t e, input int hold, input string tag);
    int          n;
    bit          busy_bad;
    bit          hold_bad;
    exp_t        g;
    logic [31:0] r0;
    @(negedge clk);
    sel8 = w8; cmd_s = c; a_s = x; b_s = y; in_valid = 1'b1;
    check({tag, " in_ready"}, {31'd0, obs_ir}, 32'd1);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0; busy_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!obs_ov && obs_ir) busy_bad = 1'b1;
    end while (!obs_ov && n < 100);
    check({tag, " latency"}, n, e.lat);
    check({tag, " busy"}, {31'd0, busy_bad}, 32'd0);
    g = sb.pop_front();
    check({tag, " result"}, obs_res, g.res);
    check({tag, " carry"}, {31'd0, obs_c}, {31'd0, g.c});
    check({tag, " ovf"}, {31'd0, obs_o}, {31'd0, g.o});
    check({tag, " zero"}, {31'd0, obs_z}, {31'd0, g.z});
    check({tag, " illegal"}, {31'd0, obs_il}, {31'd0, g.ill});
    r0 = obs_res; hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_s = 4'd0; a_s = ~x; b_s = 32'd1; in_valid = 1'b1;
      @(negedge clk);
      if (obs_res !== r0 || !obs_ov || obs_ir) hold_bad = 1'b1;
    end
    if (hold > 0) check({tag, " hold"}, {31'd0, hold_bad}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {30'd0, obs_ir, obs_ov}, 32'd2);
    @(negedge clk);
    check({tag, " no ghost"}, {31'd0, obs_ov}, 32'd0);
  endtask

  task automatic op32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                      input int hold, input string tag);
    run_op(1'b0, c, x, y, model32(c, x, y), hold, tag);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'd0, ir32}, 32'd1);
    check("reset out_valid", {31'd0, ov32}, 32'd0);
    check("reset result", r32, 32'd0);
    check("reset flags", {28'd0, c32, o32, z32, il32}, 32'd0);

    op32(4'd0, 32'h7FFFFFFF, 32'd1, 0, "add ovf");
    op32(4'd1, 32'd5, 32'd5, 0, "sub eq");
    op32(4'd3, 32'h80000000, 32'd1, 0, "slt");
    op32(4'd8, 32'h80000000, 32'd1, 0, "sltu");
    op32(4'd11, 32'h80000000, 32'd4, 0, "sra4");
    op32(4'd9, 32'h12345678, 32'd0, 0, "sll0");
    op32(4'd10, 32'hFFFFFFFF, 32'd31, 0, "srl31");
    op32(4'd0, 32'd3, 32'd4, 3, "add bp");
    op32(4'd14, 32'h55, 32'hAA, 0, "illegal32");

    // Reset part-way through a long shift
    @(negedge clk);
    sel8 = 1'b0; cmd_s = 4'd10; a_s = 32'hFFFFFFFF; b_s = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort out_valid", {31'd0, ov32}, 32'd0);
    check("abort result", r32, 32'd0);
    check("abort in_ready", {31'd0, ir32}, 32'd1);
    op32(4'd0, 32'd1, 32'd1, 0, "add after abort");

    for (int i = 0; i < 10; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      op32(rc, ra, rb, int'($urandom_range(0, 2)), "rand");
    end

    run_op(1'b1, 4'd7, 32'h0F, 32'hF0, mk(32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1), 0, "w8 nor");
    run_op(1'b1, 4'd5, 32'hFF, 32'hFF, mk(32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1), 0, "w8 nand");
    run_op(1'b1, 4'hC, 32'h12, 32'h34, mk(32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1), 0, "w8 illegal");
    run_op(1'b1, 4'd11, 32'h80, 32'h07, mk(32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8), 1, "w8 sra7");
    run_op(1'b1, 4'd0, 32'h7F, 32'h01, mk(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1), 0, "w8 add ovf");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
